// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring divide, one bit per cycle.
// Start/busy/done handshake; 34-cycle latency (2 for div-by-zero / signed overflow). Result held until next done.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W = XLEN;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   mc_q, mc_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [W-1:0]   result_q, result_d;

  logic           is_div, sgn_a, sgn_b, a_neg, b_neg, b_zero, ovf;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, div_next, step, prod_s;
  logic [W-1:0]   div_diff, quo, rem, fin;
  logic           div_ge;

  always_comb begin
    is_div = op_q[2];
    sgn_a  = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    sgn_b  = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    a_neg  = sgn_a & a_q[W-1];
    b_neg  = sgn_b & b_q[W-1];
    a_mag  = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag  = b_neg ? (~b_q + 1'b1) : b_q;
    b_zero = (b_q == '0);
    ovf    = ((op_q == 3'b100) || (op_q == 3'b110)) &&
             (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == {W{1'b1}});
  end

  // Multiply: acc = {partial product, remaining multiplier}, shifted right each step.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mc_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; the shifted-out top bit joins the trial compare.
  always_comb begin
    div_ge   = (acc_q[2*W-1:W-1] >= {1'b0, mc_q});
    div_diff = acc_q[2*W-2:W-1] - mc_q;
    div_next = div_ge ? {div_diff, acc_q[W-2:0], 1'b1} : {acc_q[2*W-2:0], 1'b0};
  end

  always_comb begin
    step   = is_div ? div_next : mul_next;
    prod_s = (neg_a_q ^ neg_b_q) ? (~step + 1'b1) : step;
    quo    = step[W-1:0];
    rem    = step[2*W-1:W];
    case (op_q)
      3'b000:                 fin = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*W-1:W];
      3'b100, 3'b101:         fin = (neg_a_q ^ neg_b_q) ? (~quo + 1'b1) : quo;
      default:                fin = neg_a_q ? (~rem + 1'b1) : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = funct3;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_a_d = a_neg;
        neg_b_d = b_neg;
        acc_d   = {{W{1'b0}}, a_mag};
        mc_d    = b_mag;
        cnt_d   = 5'd0;
        if (is_div && b_zero) begin
          result_d = op_q[1] ? a_q : {W{1'b1}};
          state_d  = S_DONE;
        end else if (ovf) begin
          result_d = op_q[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = fin;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency plus hand sequences for handshake corners.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive start for one cycle; returns at the falling edge of the cycle after acceptance.
  task automatic issue(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    funct3 = f; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp, input int lat);
    int n;
    logic busy_ok;
    issue(f, av, bv);
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!busy) busy_ok = 1'b0;
    chk({name, " latency"}, n, lat);
    chk({name, " result"}, result, exp);
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({name, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n, dones, done_n;
    logic busy35, busy36;

    vt[0]  = '{"mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vt[1]  = '{"mulhu_m1_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[2]  = '{"mulhsu_m1_2",   3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[3]  = '{"mul_min_2",     3'b000, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 34};
    vt[4]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vt[5]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vt[6]  = '{"divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        34};
    vt[7]  = '{"remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         34};
    vt[8]  = '{"divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vt[9]  = '{"rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         2};
    vt[10] = '{"div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vt[11] = '{"rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vt[12] = '{"div_m5_0",      3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 2};
    vt[13] = '{"remu_m5_0",     3'b111, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2};
    vt[14] = '{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vt[15] = '{"div_7_m2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vt[16] = '{"rem_7_m2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
    vt[17] = '{"mulhsu_2_m1",   3'b010, 32'd2,         32'hFFFF_FFFF, 32'd1,         34};
    vt[18] = '{"mulhu_m1_2",    3'b011, 32'hFFFF_FFFF, 32'd2,         32'd1,         34};
    vt[19] = '{"mul_big",       3'b000, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 34};
    vt[20] = '{"divu_big",      3'b101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34};

    reset = 1'b1; start = 1'b0; funct3 = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset state", {busy, done, result[29:0]}, 32'd0);
    chk("reset result", result, 32'd0);

    // Basic MUL, then confirm result is held and done stays low.
    run_op("mul_7_6", 3'b000, 32'd7, 32'd6, 32'd42, 34);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mul hold done", dones, 0);
    chk("mul hold result", result, 32'd42);

    for (int i = 0; i < NV; i++)
      run_op(vt[i].name, vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat);

    // Operand change and start pulses while busy (including in DONE) must be ignored.
    issue(3'b101, 32'd100, 32'd7);
    dones = 0; done_n = 0; busy35 = 1'b1; busy36 = 1'b1;
    for (n = 1; n <= 40; n++) begin
      if (done) begin dones++; done_n = n; end
      if (n == 35) busy35 = busy;
      if (n == 36) busy36 = busy;
      if (n == 3) a = 32'd5;
      if (n == 5 || n == 34) begin start = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd3; end
      if (n == 6 || n == 35) start = 1'b0;
      @(negedge clk);
    end
    chk("ignore done count", dones, 1);
    chk("ignore done cycle", done_n, 34);
    chk("ignore result", result, 32'd14);
    chk("ignore busy after", {30'd0, busy35, busy36}, 32'd0);

    // Reset mid-operation aborts with no done.
    issue(3'b000, 32'd7, 32'd6);
    n = 1;
    while (n < 20) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy/done", {30'd0, busy, done}, 32'd0);
    chk("abort result", result, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort no done", dones, 0);
    run_op("mul_2_3", 3'b000, 32'd2, 32'd3, 32'd6, 34);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; funct3 = 3'b000; a = 32'd2; b = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst+start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rst+start idle", {30'd0, busy, done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
